// File: rtl/scoreboard_stall_unit.sv
// scoreboard_stall_unit
//   Tracks the destination registers of instructions that are in flight between issue
//   (ID->EX) and writeback (MEM/WB). Stalls the ID stage while a source operand is
//   still pending and MEM/WB forwarding cannot supply it this cycle.
//
// Ports
//   clk, rst            pipeline clock; asynchronous active-high reset
//   ID_*                instruction in ID: valid, sources (+used), destination (+write)
//   MEM_WB_Rd/RegWrite  register retiring this cycle
//   Flush, ID_EX_*      squash of the instruction currently in ID_EX
//   Stall               hold PC/IF_ID and insert a bubble into ID_EX
//   Issue               the ID instruction advances this cycle
//   Busy                per-register pending flag (bit 0 always 0)
//   Err_Overflow        sticky: an issue hit a saturated counter
//   Err_Underflow       sticky: a retire or flush hit a zero counter
//   Stall_Cycles        saturating count of stalled cycles
module scoreboard_stall_unit #(
   parameter int unsigned NREG  = 32,
   parameter int unsigned CNTW  = 2,
   parameter int unsigned STATW = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ID_Valid,
   input  logic [4:0]       ID_Rs1,
   input  logic [4:0]       ID_Rs2,
   input  logic             ID_Rs1_Used,
   input  logic             ID_Rs2_Used,
   input  logic [4:0]       ID_Rd,
   input  logic             ID_RegWrite,
   input  logic [4:0]       MEM_WB_Rd,
   input  logic             MEM_WB_RegWrite,
   input  logic             Flush,
   input  logic [4:0]       ID_EX_Rd,
   input  logic             ID_EX_RegWrite,
   output logic             Stall,
   output logic             Issue,
   output logic [NREG-1:0]  Busy,
   output logic             Err_Overflow,
   output logic             Err_Underflow,
   output logic [STATW-1:0] Stall_Cycles
);

   logic [NREG-1:0][CNTW-1:0] cnt_q, cnt_d;
   logic                      ovf_q, ovf_d;
   logic                      unf_q, unf_d;
   logic [STATW-1:0]          stat_q, stat_d;

   logic fwd_rs1, fwd_rs2;
   logic haz_rs1, haz_rs2;
   logic stall, issue;

   // Per-register scratch for the next-state loop.
   logic            inc, dec_wb, dec_fl;
   logic [CNTW+1:0] net;
   logic            ovf_any, unf_any;

   // A source can be forwarded only when its sole pending writer is the one retiring now;
   // with two writers in flight the retiring value is already stale.
   always_comb begin
      fwd_rs1 = MEM_WB_RegWrite && (MEM_WB_Rd == ID_Rs1) && (ID_Rs1 != 5'd0) &&
                (cnt_q[ID_Rs1] == CNTW'(1));
      fwd_rs2 = MEM_WB_RegWrite && (MEM_WB_Rd == ID_Rs2) && (ID_Rs2 != 5'd0) &&
                (cnt_q[ID_Rs2] == CNTW'(1));
      haz_rs1 = ID_Rs1_Used && (ID_Rs1 != 5'd0) && (cnt_q[ID_Rs1] != '0) && !fwd_rs1;
      haz_rs2 = ID_Rs2_Used && (ID_Rs2 != 5'd0) && (cnt_q[ID_Rs2] != '0) && !fwd_rs2;
      stall   = ID_Valid && (haz_rs1 || haz_rs2);
      issue   = ID_Valid && !stall;
   end

   // Net update per register; the extra two bits of 'net' expose overflow (bit CNTW)
   // and underflow (sign bit CNTW+1) of the combined increment/decrements.
   always_comb begin
      cnt_d   = cnt_q;
      cnt_d[0] = '0;
      inc     = 1'b0;
      dec_wb  = 1'b0;
      dec_fl  = 1'b0;
      net     = '0;
      ovf_any = 1'b0;
      unf_any = 1'b0;
      for (int unsigned r = 1; r < NREG; r++) begin
         inc    = issue && ID_RegWrite && (ID_Rd == 5'(r));
         dec_wb = MEM_WB_RegWrite && (MEM_WB_Rd == 5'(r));
         dec_fl = Flush && ID_EX_RegWrite && (ID_EX_Rd == 5'(r));
         net    = {2'b00, cnt_q[r]} + (CNTW+2)'(inc) - (CNTW+2)'(dec_wb) -
                  (CNTW+2)'(dec_fl);
         if (net[CNTW+1]) begin
            cnt_d[r] = '0;
            unf_any  = 1'b1;
         end else if (net[CNTW]) begin
            cnt_d[r] = '1;
            ovf_any  = 1'b1;
         end else begin
            cnt_d[r] = net[CNTW-1:0];
         end
      end
      ovf_d  = ovf_q | ovf_any;
      unf_d  = unf_q | unf_any;
      stat_d = stat_q;
      if (stall && (stat_q != '1)) begin
         stat_d = stat_q + STATW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
         stat_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
         unf_q  <= unf_d;
         stat_q <= stat_d;
      end
   end

   always_comb begin
      Busy = '0;
      for (int unsigned r = 1; r < NREG; r++) begin
         Busy[r] = (cnt_q[r] != '0);
      end
   end

   assign Stall         = stall;
   assign Issue         = issue;
   assign Err_Overflow  = ovf_q;
   assign Err_Underflow = unf_q;
   assign Stall_Cycles  = stat_q;

endmodule

// File: tb/tb_scoreboard_stall_unit.sv
// Self-checking bench for scoreboard_stall_unit: a table of directed vectors (inputs plus
// expected outputs before the clock edge), followed by a hand-written async reset sequence.
module tb_scoreboard_stall_unit;

   logic        clk;
   logic        rst;
   logic        ID_Valid;
   logic [4:0]  ID_Rs1, ID_Rs2, ID_Rd;
   logic        ID_Rs1_Used, ID_Rs2_Used, ID_RegWrite;
   logic [4:0]  MEM_WB_Rd;
   logic        MEM_WB_RegWrite;
   logic        Flush;
   logic [4:0]  ID_EX_Rd;
   logic        ID_EX_RegWrite;
   logic        Stall, Issue;
   logic [31:0] Busy;
   logic        Err_Overflow, Err_Underflow;
   logic [15:0] Stall_Cycles;

   int n_total = 0;
   int n_pass  = 0;

   scoreboard_stall_unit dut (
      .clk             (clk),
      .rst             (rst),
      .ID_Valid        (ID_Valid),
      .ID_Rs1          (ID_Rs1),
      .ID_Rs2          (ID_Rs2),
      .ID_Rs1_Used     (ID_Rs1_Used),
      .ID_Rs2_Used     (ID_Rs2_Used),
      .ID_Rd           (ID_Rd),
      .ID_RegWrite     (ID_RegWrite),
      .MEM_WB_Rd       (MEM_WB_Rd),
      .MEM_WB_RegWrite (MEM_WB_RegWrite),
      .Flush           (Flush),
      .ID_EX_Rd        (ID_EX_Rd),
      .ID_EX_RegWrite  (ID_EX_RegWrite),
      .Stall           (Stall),
      .Issue           (Issue),
      .Busy            (Busy),
      .Err_Overflow    (Err_Overflow),
      .Err_Underflow   (Err_Underflow),
      .Stall_Cycles    (Stall_Cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [4:0]  rs1;
      logic        u1;
      logic [4:0]  rs2;
      logic        u2;
      logic [4:0]  rd;
      logic        rw;
      logic [4:0]  wb_rd;
      logic        wb_rw;
      logic        fl;
      logic [4:0]  ex_rd;
      logic        ex_rw;
      logic        e_stall;
      logic        e_issue;
      logic [31:0] e_busy;
      logic        e_ovf;
      logic        e_unf;
      logic [15:0] e_stat;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic v, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                      input logic rw, input logic [4:0] wb_rd, input logic wb_rw,
                      input logic fl, input logic [4:0] ex_rd, input logic ex_rw,
                      input logic e_stall, input logic e_issue, input logic [31:0] e_busy,
                      input logic e_ovf, input logic e_unf, input logic [15:0] e_stat);
      vec_t t;
      t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2; t.rd = rd; t.rw = rw;
      t.wb_rd = wb_rd; t.wb_rw = wb_rw; t.fl = fl; t.ex_rd = ex_rd; t.ex_rw = ex_rw;
      t.e_stall = e_stall; t.e_issue = e_issue; t.e_busy = e_busy;
      t.e_ovf = e_ovf; t.e_unf = e_unf; t.e_stat = e_stat;
      vecs.push_back(t);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic drive_idle();
      ID_Valid = 0; ID_Rs1 = 0; ID_Rs2 = 0; ID_Rs1_Used = 0; ID_Rs2_Used = 0;
      ID_Rd = 0; ID_RegWrite = 0; MEM_WB_Rd = 0; MEM_WB_RegWrite = 0;
      Flush = 0; ID_EX_Rd = 0; ID_EX_RegWrite = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      drive_idle();

      //     v rs1 u1 rs2 u2 rd rw wbrd wbrw fl exrd exrw | stall issue busy ovf unf stat
      // Back-to-back RAW on x5: two stall cycles, issue when x5 retires.
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,   0, 0, 0);
      add(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0,   0, 1, 32'h0,   0, 0, 0);
      add(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 32'h20,  0, 0, 0);
      add(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 32'h20,  0, 0, 1);
      add(1, 5, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0,   0, 1, 32'h20,  0, 0, 2);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,   0, 0, 2);
      // x0 writes/reads never tracked; unused pending Rs2 does not stall.
      add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,   0, 1, 32'h0,   0, 0, 2);
      add(1, 0, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0,   0, 1, 32'h0,   0, 0, 2);
      add(1, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 32'h80,  0, 0, 2);
      add(0, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0,   0, 0, 32'h80,  0, 0, 2);
      // Two writers to x9: first retire cannot forward, second can.
      add(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0,   0, 1, 32'h0,   0, 0, 2);
      add(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0,   0, 1, 32'h200, 0, 0, 2);
      add(1, 9, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0,   1, 0, 32'h200, 0, 0, 2);
      add(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 32'h200, 0, 0, 3);
      add(1, 9, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0,   0, 1, 32'h200, 0, 0, 4);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,   0, 0, 4);
      // Flush of a pending x3 write clears it without underflow.
      add(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0,   0, 1, 32'h0,   0, 0, 4);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1,   0, 0, 32'h8,   0, 0, 4);
      add(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 32'h0,   0, 0, 4);
      // Same-cycle inc and retire on x8 keeps the count at 1.
      add(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0,   0, 1, 32'h0,   0, 0, 4);
      add(1, 0, 0, 0, 0, 8, 1, 8, 1, 0, 0, 0,   0, 1, 32'h100, 0, 0, 4);
      add(0, 0, 0, 0, 0, 0, 0, 8, 1, 0, 0, 0,   0, 0, 32'h100, 0, 0, 4);
      // Retire to x0 is harmless; retire of idle x4 underflows.
      add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 32'h0,   0, 0, 4);
      add(0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0,   0, 0, 32'h0,   0, 0, 4);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,   0, 1, 4);
      // Four writers to x6: the fourth overflows, count holds at 3.
      add(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0,   0, 1, 32'h0,   0, 1, 4);
      add(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0,   0, 1, 32'h40,  0, 1, 4);
      add(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0,   0, 1, 32'h40,  0, 1, 4);
      add(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0,   0, 1, 32'h40,  0, 1, 4);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h40,  1, 1, 4);

      // Reset state; Issue follows ID_Valid while held in reset.
      #2;
      chk("reset_stall", 32'(Stall), 0);
      chk("reset_busy", Busy, 0);
      chk("reset_stat", 32'(Stall_Cycles), 0);
      ID_Valid = 1;
      #1;
      chk("reset_issue", 32'(Issue), 1);
      ID_Valid = 0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         ID_Valid = vecs[i].v; ID_Rs1 = vecs[i].rs1; ID_Rs1_Used = vecs[i].u1;
         ID_Rs2 = vecs[i].rs2; ID_Rs2_Used = vecs[i].u2;
         ID_Rd = vecs[i].rd; ID_RegWrite = vecs[i].rw;
         MEM_WB_Rd = vecs[i].wb_rd; MEM_WB_RegWrite = vecs[i].wb_rw;
         Flush = vecs[i].fl; ID_EX_Rd = vecs[i].ex_rd; ID_EX_RegWrite = vecs[i].ex_rw;
         #2;
         chk($sformatf("v%0d_stall", i), 32'(Stall), 32'(vecs[i].e_stall));
         chk($sformatf("v%0d_issue", i), 32'(Issue), 32'(vecs[i].e_issue));
         chk($sformatf("v%0d_busy", i), Busy, vecs[i].e_busy);
         chk($sformatf("v%0d_ovf", i), 32'(Err_Overflow), 32'(vecs[i].e_ovf));
         chk($sformatf("v%0d_unf", i), 32'(Err_Underflow), 32'(vecs[i].e_unf));
         chk($sformatf("v%0d_stat", i), 32'(Stall_Cycles), 32'(vecs[i].e_stat));
         @(posedge clk);
         #1;
      end

      // Async reset mid-sequence with cnt[5]=2 and a stalled reader in ID.
      drive_idle();
      ID_Valid = 1; ID_Rd = 5; ID_RegWrite = 1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      drive_idle();
      ID_Valid = 1; ID_Rs1 = 5; ID_Rs1_Used = 1;
      #2;
      chk("pre_rst_stall", 32'(Stall), 1);
      chk("pre_rst_busy", Busy, 32'h60);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_busy", Busy, 0);
      chk("async_rst_stall", 32'(Stall), 0);
      chk("async_rst_issue", 32'(Issue), 1);
      chk("async_rst_ovf", 32'(Err_Overflow), 0);
      chk("async_rst_unf", 32'(Err_Underflow), 0);
      chk("async_rst_stat", 32'(Stall_Cycles), 0);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_busy", Busy, 0);
      chk("post_rst_stat", 32'(Stall_Cycles), 0);
      chk("post_rst_stall", 32'(Stall), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/scoreboard_stall_unit.md
Name: scoreboard_stall_unit

Overview:
- Producer-side companion to the EX/WB operand forwarding logic.
- Tracks in-flight destination registers from issue (ID→EX) until retirement (MEM/WB writeback).
- Raises a stall for the ID stage whenever a source operand is still pending and cannot be supplied by MEM/WB forwarding in the current cycle.
- Sits beside the ID stage and drives the PC/IF_ID write-enables and the ID_EX bubble mux.

Parameters:
- NREG, 32, number of architectural registers; x0 is never tracked.
- CNTW, 2, width of each per-register in-flight counter; maximum 2^CNTW-1 writers in flight.
- STATW, 16, width of the saturating stall-cycle statistic counter.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- ID_Valid  input  1  the ID stage holds a real instruction.
- ID_Rs1  input  5  source register 1 of the ID instruction.
- ID_Rs2  input  5  source register 2 of the ID instruction.
- ID_Rs1_Used  input  1  the instruction reads Rs1.
- ID_Rs2_Used  input  1  the instruction reads Rs2.
- ID_Rd  input  5  destination register of the ID instruction.
- ID_RegWrite  input  1  the ID instruction writes Rd.
- MEM_WB_Rd  input  5  destination register retiring this cycle.
- MEM_WB_RegWrite  input  1  retirement write-enable.
- Flush  input  1  squash the instruction currently in ID_EX (branch taken).
- ID_EX_Rd  input  5  Rd of the instruction being squashed.
- ID_EX_RegWrite  input  1  the squashed instruction had RegWrite.
- Stall  output  1  hold PC and IF_ID, insert a bubble into ID_EX.
- Issue  output  1  the ID instruction advances this cycle.
- Busy  output  NREG  per-register pending flag (count != 0); bit 0 is always 0.
- Err_Overflow  output  1  sticky: an issue hit a saturated counter.
- Err_Underflow  output  1  sticky: a retire or flush hit a zero counter.
- Stall_Cycles  output  STATW  saturating count of cycles with Stall=1.

Behaviour:
- State: cnt[r], CNTW bits, for r = 1..NREG-1; cnt[0] is hard-wired to 0.
- Reset (async, rst=1): all cnt=0, Err_Overflow=0, Err_Underflow=0, Stall_Cycles=0. Consequently Stall=0, Busy=0, Issue=ID_Valid.
- A reset mid-operation discards all tracking immediately, with no clock required.
- Forwardable(r) = MEM_WB_RegWrite & (MEM_WB_Rd == r) & (r != 0) & (cnt[r] == 1).
- Hazard(rs) = used & (rs != 0) & (cnt[rs] != 0) & ~Forwardable(rs).
- Stall = ID_Valid & (Hazard(ID_Rs1) | Hazard(ID_Rs2)). This is combinational from registered state plus inputs; zero-cycle latency.
- Issue = ID_Valid & ~Stall.
- Per-register next-state, evaluated for each r in parallel:
  - inc = Issue & ID_RegWrite & (ID_Rd == r)
  - dec_wb = MEM_WB_RegWrite & (MEM_WB_Rd == r)
  - dec_fl = Flush & ID_EX_RegWrite & (ID_EX_Rd == r)
  - cnt[r] <= cnt[r] + inc − dec_wb − dec_fl, applying at most one decrement per source.
- Simultaneous inc and dec on the same r: the net result applies. Example: cnt=1 with inc+dec_wb stays 1.
- Overflow: if the net result would exceed 2^CNTW−1, cnt holds at max and Err_Overflow <= 1.
- Underflow: if any decrement hits cnt=0 (net below 0), cnt stays 0 and Err_Underflow <= 1.
- Both error flags are sticky until rst.
- Writes to r=0 never change state and never set errors.
- Flush with Issue in the same cycle is legal; both apply. Flush does not suppress Stall; the control unit gates ID_Valid.
- Stall_Cycles <= Stall_Cycles + 1 whenever Stall=1, saturating at all-ones.
- Stall lasts until the producer's count reaches 1 and that producer retires in MEM_WB. With a single in-flight producer issued the previous cycle, expect 2 stall cycles, then issue on the cycle its Rd appears in MEM_WB.

Test Plan:
- Reset: assert rst mid-sequence with cnt[5]=2 → Busy=0, Stall=0, errors=0, Stall_Cycles=0 asynchronously, before any clock edge.
- Back-to-back RAW: issue add x5 (RegWrite), then ID reads x5 → Stall=1 for 2 cycles. On the cycle MEM_WB_Rd=5 with RegWrite, Stall=0 and Issue=1; cnt[5] returns to 0 the next edge and Stall_Cycles=2.
- x0 and unused sources: issue writes to x0, then read x0; also Rs2=x7 pending with ID_Rs2_Used=0 → Stall=0 and Busy[0]=0 throughout.
- Double producer: two writes to x9 in flight (cnt=2), retire the first → Stall stays 1 because Forwardable requires cnt=1. Retire the second → Stall=0.
- Flush: issue a write to x3, then Flush with ID_EX_Rd=3, ID_EX_RegWrite=1 → cnt[3]=0 next edge, no stall on a later x3 read, Err_Underflow=0.
- Error flags: retire x4 with cnt[4]=0 → Err_Underflow=1 and sticky. Issue 4 writes to x6 with no retire → cnt[6]=3 and Err_Overflow=1. Apply rst → both flags clear.
